// File: rtl/reg_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_pkg
// Shared definitions for the register scoreboard:
//   REG_IDX_W            register-index width (5 -> x0..x31)
//   reg_idx_t            register-index type
//   REG_ZERO             index of the hard-wired zero register
//   MAX_OUTSTANDING_DEF  default number of simultaneously pending registers
//   idx_onehot()         decodes an index into a 32-bit one-hot vector
// -----------------------------------------------------------------------------
package reg_scoreboard_pkg;

    localparam int REG_IDX_W           = 5;
    localparam int NUM_REGS            = 32;
    localparam int MAX_OUTSTANDING_DEF = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [NUM_REGS-1:0]  reg_vec_t;

    localparam reg_idx_t REG_ZERO = '0;

    // One-hot decode of a register index, gated by an enable. x0 never
    // decodes to a set bit, so callers never need to special-case it.
    function automatic reg_vec_t idx_onehot(input reg_idx_t idx, input logic en);
        reg_vec_t v;
        v = '0;
        if (en && (idx != REG_ZERO)) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_match.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_sb_match
// Combinational lookup of one register index in the pending vector.
//   idx_i        register index to look up
//   use_i        the lookup is meaningful (source actually read / rd checked)
//   pend_i       pending vector, bit 0 always 0
//   wbk_valid_i  writeback retiring this cycle   (SCOREBOARD_BYPASS_EN only)
//   wbk_rd_i     retiring register index         (SCOREBOARD_BYPASS_EN only)
//   hit_o        index is pending (and not being retired when bypassed)
// Configuration macro: SCOREBOARD_BYPASS_EN -- when defined, a register being
// retired in the current cycle is treated as already free, relying on the
// register-file write-through path.
// -----------------------------------------------------------------------------
module reg_scoreboard_sb_match
    import reg_scoreboard_pkg::*;
(
    input  reg_idx_t idx_i,
    input  logic     use_i,
    input  reg_vec_t pend_i,
`ifdef SCOREBOARD_BYPASS_EN
    input  logic     wbk_valid_i,
    input  reg_idx_t wbk_rd_i,
`endif
    output logic     hit_o
);

    logic raw_hit;

    // x0 can never be pending; the explicit compare keeps that true even if
    // pend_i[0] were ever disturbed upstream.
    assign raw_hit = use_i && (idx_i != REG_ZERO) && pend_i[idx_i];

`ifdef SCOREBOARD_BYPASS_EN
    logic retiring;
    assign retiring = wbk_valid_i && (wbk_rd_i == idx_i);
    assign hit_o    = raw_hit && !retiring;
`else
    assign hit_o    = raw_hit;
`endif

endmodule

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Tracks destination registers of in-flight long-latency instructions
// (loads, multi-cycle MUL/DIV) from issue out of Decode until Writeback
// retires them, and raises a Decode stall request on RAW/WAW/capacity hazards.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   dec_valid_i                  Decode holds a valid instruction
//   dec_rs1_i/_use_i             source 1 index / actually read
//   dec_rs2_i/_use_i             source 2 index / actually read
//   dec_rd_i                     destination index
//   dec_long_i                   instruction is long-latency
//   dec_issue_i                  instruction leaves Decode this cycle
//   flush2exe_i                  kill of the instruction now in Execute
//   flush_all_i                  system jump, kills everything in flight
//   wbk_valid_i, wbk_rd_i        long-latency retire port
//   is_load_hazard_o             combinational stall request
//   pending_o                    registered pending vector (bit 0 always 0)
//   count_o                      registered number of pending registers
//   full_o                       registered count_o == MAX_OUTSTANDING
//
// Configuration macro: SCOREBOARD_BYPASS_EN (see reg_scoreboard_sb_match).
// -----------------------------------------------------------------------------
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dec_valid_i,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic        dec_rs1_use_i,
    input  logic        dec_rs2_use_i,
    input  logic [4:0]  dec_rd_i,
    input  logic        dec_long_i,
    input  logic        dec_issue_i,
    input  logic        flush2exe_i,
    input  logic        flush_all_i,
    input  logic        wbk_valid_i,
    input  logic [4:0]  wbk_rd_i,
    output logic        is_load_hazard_o,
    output logic [31:0] pending_o,
    output logic [4:0]  count_o,
    output logic        full_o
);

    localparam logic [4:0] MAX_CNT = 5'(MAX_OUTSTANDING);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    reg_vec_t   pend_q, pend_d;
    logic [4:0] count_q, count_d;
    logic       full_q, full_d;
    reg_idx_t   last_rd_q, last_rd_d;
    logic       last_vld_q, last_vld_d;

    // ---------------------------------------------------------------------
    // Event decode
    // ---------------------------------------------------------------------
    logic     set_en, ret_en, kill_en;
    logic     set_inc, kill_dec;
    reg_vec_t set_vec, ret_vec, kill_vec, clr_vec;

    assign set_en  = dec_issue_i && dec_long_i && (dec_rd_i != REG_ZERO);
    // Retiring a register that is not pending is a no-op.
    assign ret_en  = wbk_valid_i && (wbk_rd_i != REG_ZERO) && pend_q[wbk_rd_i];
    assign kill_en = flush2exe_i && last_vld_q && pend_q[last_rd_q];

    assign set_vec  = idx_onehot(dec_rd_i,  set_en);
    assign ret_vec  = idx_onehot(wbk_rd_i,  ret_en);
    assign kill_vec = idx_onehot(last_rd_q, kill_en);
    assign clr_vec  = ret_vec | kill_vec;

    // Count changes are derived per distinct bit so the count can never drift
    // from the population of pend_q:
    //  - a kill of the register also retiring this cycle is counted once;
    //  - a set only adds if the bit is not already pending after clears
    //    (a bypassed retire followed by re-issue of the same rd is net zero).
    assign kill_dec = kill_en && !(ret_en && (wbk_rd_i == last_rd_q));
    assign set_inc  = set_en && !(pend_q[dec_rd_i] && !clr_vec[dec_rd_i]);

    // ---------------------------------------------------------------------
    // Per-register next state; flush_all wins over every set/retire/kill.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_d[gi] = 1'b0;
            end else begin : g_reg
                assign pend_d[gi] = !flush_all_i &&
                                    ((pend_q[gi] && !clr_vec[gi]) || set_vec[gi]);
            end
        end
    endgenerate

    always_comb begin
        count_d    = count_q;
        last_rd_d  = last_rd_q;
        last_vld_d = 1'b0;

        if (flush_all_i) begin
            count_d    = '0;
            last_vld_d = 1'b0;
        end else begin
            count_d = count_q + 5'(set_inc) - 5'(ret_en) - 5'(kill_dec);
            if (set_en) begin
                last_rd_d  = dec_rd_i;
                last_vld_d = 1'b1;
            end
        end

        full_d = (count_d == MAX_CNT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            last_rd_q  <= REG_ZERO;
            last_vld_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            count_q    <= count_d;
            full_q     <= full_d;
            last_rd_q  <= last_rd_d;
            last_vld_q <= last_vld_d;
        end
    end

    // ---------------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------------
    logic hit_rs1, hit_rs2, hit_rd;

    reg_scoreboard_sb_match u_match_rs1 (
        .idx_i       (dec_rs1_i),
        .use_i       (dec_rs1_use_i),
        .pend_i      (pend_q),
`ifdef SCOREBOARD_BYPASS_EN
        .wbk_valid_i (wbk_valid_i),
        .wbk_rd_i    (wbk_rd_i),
`endif
        .hit_o       (hit_rs1)
    );

    reg_scoreboard_sb_match u_match_rs2 (
        .idx_i       (dec_rs2_i),
        .use_i       (dec_rs2_use_i),
        .pend_i      (pend_q),
`ifdef SCOREBOARD_BYPASS_EN
        .wbk_valid_i (wbk_valid_i),
        .wbk_rd_i    (wbk_rd_i),
`endif
        .hit_o       (hit_rs2)
    );

    // WAW: rd is always checked; x0 is filtered inside the matcher.
    reg_scoreboard_sb_match u_match_rd (
        .idx_i       (dec_rd_i),
        .use_i       (1'b1),
        .pend_i      (pend_q),
`ifdef SCOREBOARD_BYPASS_EN
        .wbk_valid_i (wbk_valid_i),
        .wbk_rd_i    (wbk_rd_i),
`endif
        .hit_o       (hit_rd)
    );

    assign is_load_hazard_o = dec_valid_i &&
                              (hit_rs1 || hit_rs2 || hit_rd || (dec_long_i && full_q));

    assign pending_o = pend_q;
    assign count_o   = count_q;
    assign full_o    = full_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_rs1_use, dec_rs2_use, dec_long, dec_issue;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        flush2exe, flush_all, wbk_valid;
    logic [4:0]  wbk_rd;
    logic        hazard;
    logic [31:0] pending;
    logic [4:0]  count;
    logic        full;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .dec_valid_i      (dec_valid),
        .dec_rs1_i        (dec_rs1),
        .dec_rs2_i        (dec_rs2),
        .dec_rs1_use_i    (dec_rs1_use),
        .dec_rs2_use_i    (dec_rs2_use),
        .dec_rd_i         (dec_rd),
        .dec_long_i       (dec_long),
        .dec_issue_i      (dec_issue),
        .flush2exe_i      (flush2exe),
        .flush_all_i      (flush_all),
        .wbk_valid_i      (wbk_valid),
        .wbk_rd_i         (wbk_rd),
        .is_load_hazard_o (hazard),
        .pending_o        (pending),
        .count_o          (count),
        .full_o           (full)
    );

    // ---------------- behavioural reference model ----------------
    // Set of pending registers, plus the register issued last cycle.
    bit [31:0] m_pend;
    int        m_last_rd;
    bit        m_last_vld;

    function automatic int m_count();
        return $countones(m_pend);
    endfunction

    function automatic bit m_is_pending(input int idx);
        if (idx == 0) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
        if (wbk_valid && (int'(wbk_rd) == idx)) return 1'b0;
`endif
        return m_pend[idx];
    endfunction

    function automatic bit m_hazard();
        if (!dec_valid) return 1'b0;
        if (dec_rs1_use && m_is_pending(int'(dec_rs1))) return 1'b1;
        if (dec_rs2_use && m_is_pending(int'(dec_rs2))) return 1'b1;
        if (m_is_pending(int'(dec_rd))) return 1'b1;
        if (dec_long && (m_count() == MAXO)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        if (flush_all) begin
            m_pend     = '0;
            m_last_vld = 1'b0;
        end else begin
            if (wbk_valid && wbk_rd != 0) m_pend[wbk_rd] = 1'b0;
            if (flush2exe && m_last_vld) m_pend[m_last_rd] = 1'b0;
            if (dec_issue && dec_long && dec_rd != 0) begin
                m_pend[dec_rd] = 1'b1;
                m_last_rd      = int'(dec_rd);
                m_last_vld     = 1'b1;
            end else begin
                m_last_vld = 1'b0;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_use = 0; dec_rs2_use = 0;
        dec_rd = 0; dec_long = 0; dec_issue = 0;
        flush2exe = 0; flush_all = 0; wbk_valid = 0; wbk_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        idle();
        dec_valid = 1; dec_long = 1; dec_rd = rd; dec_issue = 1;
        tick();
        idle();
    endtask

    task automatic clean();
        idle();
        flush_all = 1;
        tick();
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 1;
        m_pend = '0; m_last_vld = 0; m_last_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (pending !== 32'h0) $display("FAIL reset_pending_during got %h want 0", pending); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL reset_count_during got %0d want 0", count); else n_pass++;
        @(negedge clk);
        rst = 0;
        tick();
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
        n_checks++; if (hazard !== 1'b0) $display("FAIL reset_hazard got %b want 0", hazard); else n_pass++;
        dec_valid = 1; dec_rs1 = 5; dec_rs1_use = 1; dec_rd = 6;
        #1;
        n_checks++; if (hazard !== 1'b0) $display("FAIL idle_decode_rs1_5 hazard got %b want 0", hazard); else n_pass++;
        $display("test_reset: done");
        idle();
    endtask

    task automatic test_load_use();
        logic exp_r;
        issue_long(5'd5);
        // add x6, x5, x1 sits in Decode
        dec_valid = 1; dec_rs1 = 5; dec_rs1_use = 1; dec_rs2 = 1; dec_rs2_use = 1; dec_rd = 6;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_checks++; if (hazard !== 1'b1) $display("FAIL load_use_cycle%0d hazard got %b want 1", c, hazard); else n_pass++;
            tick();
        end
        wbk_valid = 1; wbk_rd = 5;
        #1;
`ifdef SCOREBOARD_BYPASS_EN
        exp_r = 1'b0;
`else
        exp_r = 1'b1;
`endif
        n_checks++; if (hazard !== exp_r) $display("FAIL load_use_retire_cycle hazard got %b want %b", hazard, exp_r); else n_pass++;
        tick();
        wbk_valid = 0;
        #1;
        n_checks++; if (hazard !== 1'b0) $display("FAIL load_use_after_retire hazard got %b want 0", hazard); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL load_use_count got %0d want 0", count); else n_pass++;
        $display("test_load_use: done");
        idle();
    endtask

    task automatic test_flush2exe();
        issue_long(5'd7);
        flush2exe = 1;
        tick();
        idle();
        n_checks++; if (pending[7] !== 1'b0) $display("FAIL kill_pend7 got %b want 0", pending[7]); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL kill_count got %0d want 0", count); else n_pass++;
        dec_valid = 1; dec_rs1 = 7; dec_rs1_use = 1; dec_rd = 10;
        #1;
        n_checks++; if (hazard !== 1'b0) $display("FAIL kill_dependent hazard got %b want 0", hazard); else n_pass++;
        $display("test_flush2exe: done");
        clean();
    endtask

    task automatic test_capacity();
        for (int r = 1; r <= 4; r++) issue_long(5'(r));
        n_checks++; if (full !== 1'b1) $display("FAIL cap_full got %b want 1", full); else n_pass++;
        n_checks++; if (count !== 5'd4) $display("FAIL cap_count got %0d want 4", count); else n_pass++;
        n_checks++; if (pending !== 32'h1E) $display("FAIL cap_pending got %h want 1e", pending); else n_pass++;
        dec_valid = 1; dec_long = 1; dec_rd = 9;
        #1;
        n_checks++; if (hazard !== 1'b1) $display("FAIL cap_fifth_hazard got %b want 1", hazard); else n_pass++;
        wbk_valid = 1; wbk_rd = 2;
        tick();
        wbk_valid = 0;
        #1;
        n_checks++; if (full !== 1'b0) $display("FAIL cap_after_retire_full got %b want 0", full); else n_pass++;
        n_checks++; if (hazard !== 1'b0) $display("FAIL cap_after_retire_hazard got %b want 0", hazard); else n_pass++;
        dec_issue = 1;
        tick();
        idle();
        n_checks++; if (pending !== 32'h21A) $display("FAIL cap_fifth_issued pending got %h want 21a", pending); else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL cap_refull got %b want 1", full); else n_pass++;
        $display("test_capacity: done");
        clean();
    endtask

    task automatic test_flush_all();
        issue_long(5'd1);
        flush_all = 1;
        dec_valid = 1; dec_long = 1; dec_rd = 3; dec_issue = 1;
        wbk_valid = 1; wbk_rd = 1;
        tick();
        idle();
        n_checks++; if (pending !== 32'h0) $display("FAIL flush_all_pending got %h want 0", pending); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL flush_all_count got %0d want 0", count); else n_pass++;
        $display("test_flush_all: done");
    endtask

    task automatic test_x0_waw();
        issue_long(5'd0);
        n_checks++; if (pending !== 32'h0) $display("FAIL x0_pending got %h want 0", pending); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL x0_count got %0d want 0", count); else n_pass++;
        dec_valid = 1; dec_rs1 = 0; dec_rs1_use = 1; dec_rs2 = 0; dec_rs2_use = 1; dec_rd = 0;
        #1;
        n_checks++; if (hazard !== 1'b0) $display("FAIL x0_read_hazard got %b want 0", hazard); else n_pass++;
        issue_long(5'd8);
        dec_valid = 1; dec_rd = 8; dec_rs1 = 2; dec_rs1_use = 1;
        #1;
        n_checks++; if (hazard !== 1'b1) $display("FAIL waw_rd8_hazard got %b want 1", hazard); else n_pass++;
        $display("test_x0_waw: done");
        clean();
    endtask

    task automatic test_async_reset();
        issue_long(5'd12);
        issue_long(5'd13);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        n_checks++; if (pending !== 32'h0) $display("FAIL async_reset_pending got %h want 0", pending); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL async_reset_count got %0d want 0", count); else n_pass++;
        m_pend = '0; m_last_vld = 0;
        @(negedge clk);
        rst = 0;
        $display("test_async_reset: done");
    endtask

    task automatic test_random();
        int pend_list[$];
        int errs_before;
        errs_before = n_checks - n_pass;
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_rs1     = 5'($urandom_range(0, 15));
            dec_rs2     = 5'($urandom_range(0, 15));
            dec_rs1_use = 1'($urandom_range(0, 1));
            dec_rs2_use = 1'($urandom_range(0, 1));
            dec_rd      = 5'($urandom_range(0, 15));
            dec_long    = ($urandom_range(0, 2) != 0);
            flush2exe   = ($urandom_range(0, 9) == 0);
            flush_all   = ($urandom_range(0, 39) == 0);
            pend_list.delete();
            for (int r = 1; r < 32; r++) if (m_pend[r]) pend_list.push_back(r);
            if (pend_list.size() > 0 && $urandom_range(0, 2) == 0) begin
                wbk_valid = 1;
                wbk_rd    = 5'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
            end else if ($urandom_range(0, 9) == 0) begin
                wbk_valid = 1;
                wbk_rd    = 5'($urandom_range(0, 31));
            end
            // Upstream never issues while the hazard is up.
            dec_issue = dec_valid && !m_hazard() && ($urandom_range(0, 3) != 0);
            #1;
            n_checks++; if (hazard !== m_hazard()) $display("FAIL rand_hazard cyc %0d got %b want %b", cyc, hazard, m_hazard()); else n_pass++;
            tick();
            n_checks++; if (pending !== m_pend) $display("FAIL rand_pending cyc %0d got %h want %h", cyc, pending, m_pend); else n_pass++;
            n_checks++; if (count !== 5'(m_count())) $display("FAIL rand_count cyc %0d got %0d want %0d", cyc, count, m_count()); else n_pass++;
            n_checks++; if (full !== (m_count() == MAXO)) $display("FAIL rand_full cyc %0d got %b want %b", cyc, full, (m_count() == MAXO)); else n_pass++;
        end
        $display("test_random: 400 cycles, %0d new failures", (n_checks - n_pass) - errs_before);
        clean();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_flush2exe();
        test_capacity();
        test_flush_all();
        test_x0_waw();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
